// File: rtl/dtcm_port_arbiter.sv
// dtcm_port_arbiter: arbitrates writeback stores and execute loads onto a
// byte-wide DTCM port. Each access is split into 1, 2 or 4 byte beats.
// Loads are reassembled little-endian and then sign- or zero-extended.
module dtcm_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              dtcm_we,
  output logic              dtcm_re,
  output logic [ADDR_W-1:0] dtcm_addr,
  output logic [7:0]        dtcm_wdata,
  input  logic [7:0]        dtcm_rdata,
  output logic              busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SC_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_LWAIT = 2'd3
  } state_e;

  // Index of the last byte beat for a size code (11 behaves as a word).
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Sign- or zero-extend the assembled bytes according to the load size.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] val,
                                               input logic [1:0]        last,
                                               input logic              uns);
    logic [DATA_W-1:0] res;
    case (last)
      2'd0:    res = {{24{~uns & val[7]}}, val[7:0]};
      2'd1:    res = {{16{~uns & val[15]}}, val[15:0]};
      default: res = val;
    endcase
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic [DATA_W-9:0]   sdata_q, sdata_d;
  logic                uns_q, uns_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;

  logic                is_idle;
  logic                starved;
  logic                st_grant;
  logic                ld_grant;
  logic [1:0]          lane;
  logic [DATA_W-1:0]   asm_full;

  assign is_idle  = (state_q == S_IDLE);
  assign starved  = (starve_q == SC_W'(STARVE_MAX));
  assign ld_ready = is_idle && (!st_valid || starved);
  assign st_ready = is_idle && !(ld_valid && starved);
  assign st_grant = st_valid && st_ready;
  assign ld_grant = ld_valid && ld_ready;

  assign busy       = !is_idle;
  assign ld_rvalid  = rvalid_q;
  assign ld_rdata   = rdata_q;
  assign dtcm_we    = we_q;
  assign dtcm_re    = re_q;
  assign dtcm_addr  = addr_q;
  assign dtcm_wdata = wdata_q;

  // Merge the read byte returned this cycle into its lane of the assembly register.
  always_comb begin
    lane     = (state_q == S_LWAIT) ? last_q : (cnt_q - 2'd1);
    asm_full = asm_q;
    asm_full[{lane, 3'b000} +: BYTE_W] = dtcm_rdata;
  end

  // Next-state, arbitration and beat sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sdata_d  = sdata_q;
    uns_d    = uns_q;
    asm_d    = asm_q;
    starve_d = starve_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (ld_grant) begin
          state_d  = S_LOAD;
          cnt_d    = 2'd0;
          last_d   = last_idx(ld_size);
          uns_d    = ld_unsigned;
          asm_d    = '0;
          starve_d = '0;
          re_d     = 1'b1;
          addr_d   = ld_addr;
        end else if (st_grant) begin
          state_d = S_STORE;
          cnt_d   = 2'd0;
          last_d  = last_idx(st_size);
          sdata_d = st_data[DATA_W-1:BYTE_W];
          we_d    = 1'b1;
          addr_d  = st_addr;
          wdata_d = st_data[BYTE_W-1:0];
          if (!ld_valid) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + SC_W'(1);
          end
        end else if (!ld_valid) begin
          starve_d = '0;
        end
      end

      S_STORE: begin
        if (cnt_q == last_q) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          we_d    = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          wdata_d = sdata_q[BYTE_W-1:0];
          sdata_d = {8'h00, sdata_q[DATA_W-9:BYTE_W]};
        end
      end

      S_LOAD: begin
        if (cnt_q != 2'd0) begin
          asm_d = asm_full;
        end
        if (cnt_q == last_q) begin
          state_d = S_LWAIT;
          cnt_d   = 2'd0;
        end else begin
          cnt_d  = cnt_q + 2'd1;
          re_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_LWAIT: begin
        asm_d    = asm_full;
        rdata_d  = extend(asm_full, last_q, uns_q);
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      sdata_q  <= '0;
      uns_q    <= 1'b0;
      asm_q    <= '0;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      sdata_q  <= sdata_d;
      uns_q    <= uns_d;
      asm_q    <= asm_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule
